jtag_tap_sync: RTL and testbench

Oversampled IEEE 1149.1 TAP controller that sits directly downstream of the `jtag_dpi` pad driver. It consumes the `tck`/`tms`/`tdi` pad signals and returns `tdo`. JTAG inputs are synchronised into the system `clk` domain and TCK edges are detected there. The block runs the 16-state TAP FSM with an instruction register and IDCODE, BYPASS and USER data registers, and exposes the USER register to core logic.

---
 rtl/jtag_tap_sync.sv | 177 +++++++++++++++++
 tb/tb_jtag_tap_sync.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_sync.sv
// Oversampled IEEE 1149.1 TAP controller: JTAG pads are synchronised into clk, TCK edges are
// detected there, and the TAP FSM drives IR, IDCODE, BYPASS and USER data registers.
module jtag_tap_sync #(
  parameter int unsigned       IR_LEN       = 4,
  parameter logic [31:0]       IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_LEN-1:0] IDCODE_OP    = 4'h1,
  parameter logic [IR_LEN-1:0] BYPASS_OP    = 4'hF,
  parameter logic [IR_LEN-1:0] USER_OP      = 4'h8,
  parameter int unsigned       USER_LEN     = 32,
  parameter int unsigned       SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_oe,
  output logic [3:0]          tap_state,
  output logic [IR_LEN-1:0]   ir_out,
  input  logic [USER_LEN-1:0] user_capture_data,
  output logic [USER_LEN-1:0] user_update_data,
  output logic                user_update_valid
);

  typedef enum logic [3:0] {
    StTlr    = 4'hF,
    StRti    = 4'hC,
    StSelDr  = 4'h7,
    StCapDr  = 4'h6,
    StShDr   = 4'h2,
    StEx1Dr  = 4'h1,
    StPauDr  = 4'h3,
    StEx2Dr  = 4'h0,
    StUpdDr  = 4'h5,
    StSelIr  = 4'h4,
    StCapIr  = 4'hE,
    StShIr   = 4'hA,
    StEx1Ir  = 4'h9,
    StPauIr  = 4'hB,
    StEx2Ir  = 4'h8,
    StUpdIr  = 4'hD
  } tap_state_e;

  localparam logic [IR_LEN-1:0] IrCapture = IR_LEN'(4'b0101);

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic                   tck_prev;
  logic                   tck_s, tms_s, tdi_s;
  logic                   rise, fall;

  tap_state_e             state_q, state_d;
  logic [IR_LEN-1:0]      ir_sr;
  logic [31:0]            idcode_sr;
  logic                   bypass_sr;
  logic [USER_LEN-1:0]    user_sr;
  logic                   dr_bit0;

  assign tck_s = tck_sync[SYNC_STAGES-1];
  assign tms_s = tms_sync[SYNC_STAGES-1];
  assign tdi_s = tdi_sync[SYNC_STAGES-1];
  assign rise  = tck_s & ~tck_prev;
  assign fall  = ~tck_s & tck_prev;

  assign tap_state = state_q;

  // tms/tdi share tck's delay so they are sampled as they were at the pad edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_prev <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
      tck_prev <= tck_s;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rise) begin
      unique case (state_q)
        StTlr:   state_d = tms_s ? StTlr   : StRti;
        StRti:   state_d = tms_s ? StSelDr : StRti;
        StSelDr: state_d = tms_s ? StSelIr : StCapDr;
        StCapDr: state_d = tms_s ? StEx1Dr : StShDr;
        StShDr:  state_d = tms_s ? StEx1Dr : StShDr;
        StEx1Dr: state_d = tms_s ? StUpdDr : StPauDr;
        StPauDr: state_d = tms_s ? StEx2Dr : StPauDr;
        StEx2Dr: state_d = tms_s ? StUpdDr : StShDr;
        StUpdDr: state_d = tms_s ? StSelDr : StRti;
        StSelIr: state_d = tms_s ? StTlr   : StCapIr;
        StCapIr: state_d = tms_s ? StEx1Ir : StShIr;
        StShIr:  state_d = tms_s ? StEx1Ir : StShIr;
        StEx1Ir: state_d = tms_s ? StUpdIr : StPauIr;
        StPauIr: state_d = tms_s ? StEx2Ir : StPauIr;
        StEx2Ir: state_d = tms_s ? StUpdIr : StShIr;
        StUpdIr: state_d = tms_s ? StSelDr : StRti;
      endcase
    end
  end

  // Unrecognised opcodes fall through to the bypass bit.
  always_comb begin
    if (ir_out == IDCODE_OP) begin
      dr_bit0 = idcode_sr[0];
    end else if (ir_out == USER_OP) begin
      dr_bit0 = user_sr[0];
    end else begin
      dr_bit0 = bypass_sr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StTlr;
      ir_sr             <= '0;
      idcode_sr         <= '0;
      bypass_sr         <= 1'b0;
      user_sr           <= '0;
      ir_out            <= IDCODE_OP;
      user_update_data  <= '0;
      user_update_valid <= 1'b0;
    end else begin
      state_q           <= state_d;
      user_update_valid <= 1'b0;
      if (rise) begin
        unique case (state_q)
          StCapIr: ir_sr <= IrCapture;
          StShIr:  ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
          StCapDr: begin
            if (ir_out == IDCODE_OP) begin
              idcode_sr <= IDCODE_VALUE;
            end else if (ir_out == USER_OP) begin
              user_sr <= user_capture_data;
            end else begin
              bypass_sr <= 1'b0;
            end
          end
          StShDr: begin
            if (ir_out == IDCODE_OP) begin
              idcode_sr <= {tdi_s, idcode_sr[31:1]};
            end else if (ir_out == USER_OP) begin
              user_sr <= {tdi_s, user_sr[USER_LEN-1:1]};
            end else begin
              bypass_sr <= tdi_s;
            end
          end
          default: ;
        endcase
        if (state_d == StUpdIr) begin
          ir_out <= ir_sr;
        end else if (state_d == StTlr) begin
          ir_out <= IDCODE_OP;
        end
        if (state_d == StUpdDr && ir_out == USER_OP) begin
          user_update_data  <= user_sr;
          user_update_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else if (fall) begin
      tdo    <= (state_q == StShIr) ? ir_sr[0] : (state_q == StShDr) ? dr_bit0 : 1'b0;
      tdo_oe <= (state_q == StShIr) || (state_q == StShDr);
    end
  end

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Directed bench for jtag_tap_sync: pad-level JTAG stimulus, a TAP-level reference model,
// and literal expectations for each scripted transaction.
module tb_jtag_tap_sync;

  localparam int PH = 6;

  logic        clk = 1'b0;
  logic        rst_n, tck, tms, tdi;
  logic        tdo, tdo_oe, user_update_valid;
  logic [3:0]  tap_state, ir_out;
  logic [31:0] user_capture_data, user_update_data;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  bit settled = 1'b0;

  // Reference model state
  logic [3:0]  m_state, m_ir, m_irsr;
  logic [31:0] m_dr, m_upd;
  int          m_len;
  logic        m_tdo, m_oe;

  jtag_tap_sync dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tck               (tck),
    .tms               (tms),
    .tdi               (tdi),
    .tdo               (tdo),
    .tdo_oe            (tdo_oe),
    .tap_state         (tap_state),
    .ir_out            (ir_out),
    .user_capture_data (user_capture_data),
    .user_update_data  (user_update_data),
    .user_update_valid (user_update_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
    case (s)
      4'hF: return t ? 4'hF : 4'hC;
      4'hC: return t ? 4'h7 : 4'hC;
      4'h7: return t ? 4'h4 : 4'h6;
      4'h6: return t ? 4'h1 : 4'h2;
      4'h2: return t ? 4'h1 : 4'h2;
      4'h1: return t ? 4'h5 : 4'h3;
      4'h3: return t ? 4'h0 : 4'h3;
      4'h0: return t ? 4'h5 : 4'h2;
      4'h5: return t ? 4'h7 : 4'hC;
      4'h4: return t ? 4'hF : 4'hE;
      4'hE: return t ? 4'h9 : 4'hA;
      4'hA: return t ? 4'h9 : 4'hA;
      4'h9: return t ? 4'hD : 4'hB;
      4'hB: return t ? 4'h8 : 4'hB;
      4'h8: return t ? 4'hD : 4'hA;
      4'hD: return t ? 4'h7 : 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 4'hF; m_ir = 4'h1; m_irsr = '0; m_dr = '0; m_len = 1;
    m_upd = '0; m_tdo = 1'b0; m_oe = 1'b0;
  endtask

  task automatic model_rise(input logic t_ms, input logic t_di);
    logic [3:0] nxt;
    nxt = tap_next(m_state, t_ms);
    if (m_state == 4'hE) m_irsr = 4'b0101;
    if (m_state == 4'hA) m_irsr = {t_di, m_irsr[3:1]};
    if (m_state == 4'h6) begin
      if (m_ir == 4'h1) begin m_dr = 32'h149511C3; m_len = 32; end
      else if (m_ir == 4'h8) begin m_dr = user_capture_data; m_len = 32; end
      else begin m_dr = '0; m_len = 1; end
    end
    if (m_state == 4'h2) begin
      m_dr = m_dr >> 1;
      m_dr[m_len-1] = t_di;
    end
    if (nxt == 4'hD) m_ir = m_irsr;
    if (nxt == 4'hF) m_ir = 4'h1;
    if (nxt == 4'h5 && m_ir == 4'h8) m_upd = m_dr;
    m_state = nxt;
  endtask

  task automatic model_fall();
    m_tdo = (m_state == 4'hA) ? m_irsr[0] : (m_state == 4'h2) ? m_dr[0] : 1'b0;
    m_oe  = (m_state == 4'hA) || (m_state == 4'h2);
  endtask

  // Settled outputs must track the model; update pulses only occur mid-transition.
  always @(negedge clk) begin
    if (settled && rst_n) begin
      check("state", tap_state, m_state);
      check("ir_out", ir_out, m_ir);
      check("tdo", tdo, m_tdo);
      check("tdo_oe", tdo_oe, m_oe);
      check("upd_data", user_update_data, m_upd);
      check("valid_idle", user_update_valid, 1'b0);
    end
  end

  always @(negedge clk) if (user_update_valid) pulse_cnt++;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tck_cycle(input logic t_ms, input logic t_di, output logic b);
    tms = t_ms; tdi = t_di;
    wait_clks(2);
    settled = 1'b0; tck = 1'b1; model_rise(t_ms, t_di);
    wait_clks(PH); settled = 1'b1; wait_clks(2);
    settled = 1'b0; tck = 1'b0; model_fall();
    wait_clks(PH); settled = 1'b1; b = tdo;
    wait_clks(1);
  endtask

  task automatic walk(input logic [7:0] tms_seq, input int n, output logic b);
    for (int i = 0; i < n; i++) tck_cycle(tms_seq[i], 1'b0, b);
  endtask

  // From TLR/RTI/Upd*: to ShDR (returns first shifted bit).
  task automatic enter_dr(output logic b0);
    walk(8'b0010, 4, b0);
  endtask

  task automatic enter_ir(output logic b0);
    walk(8'b00110, 5, b0);
  endtask

  // Shifts n bits LSB first, leaving on the last; ends in Exit1.
  task automatic shift_bits(input int n, input logic [63:0] vin, input logic b0,
                            output logic [63:0] vout);
    logic b;
    vout = '0;
    vout[0] = b0;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, vin[i], b);
      if (i < n - 1) vout[i+1] = b;
    end
  endtask

  task automatic load_ir(input logic [3:0] op);
    logic b0, b;
    logic [63:0] vo;
    enter_ir(b0);
    shift_bits(4, {60'd0, op}, b0, vo);
    tck_cycle(1'b1, 1'b0, b);
  endtask

  initial begin
    logic        b, b0;
    logic [63:0] vo;
    int          p0;

    rst_n = 1'b0; tck = 1'b0; tms = 1'b0; tdi = 1'b0;
    user_capture_data = 32'hDEADBEEF;
    model_reset();

    // Reset held while tck toggles
    for (int i = 0; i < 4; i++) begin
      tck = ~tck; tms = 1'b1; tdi = ~tdi;
      wait_clks(5);
      check("rst_state", tap_state, 4'hF);
      check("rst_ir", ir_out, 4'h1);
      check("rst_tdo", {tdo, tdo_oe}, 2'b00);
    end
    tck = 1'b0; tms = 1'b0;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(5);
    settled = 1'b1;
    check("post_rst_state", tap_state, 4'hF);

    // IDCODE read
    enter_dr(b0);
    check("shdr_state", tap_state, 4'h2);
    check("shdr_oe", tdo_oe, 1'b1);
    shift_bits(32, 64'd0, b0, vo);
    check("idcode", vo[31:0], 32'h149511C3);
    tck_cycle(1'b1, 1'b0, b);
    check("upd_dr_state", tap_state, 4'h5);

    // IR capture and BYPASS
    enter_ir(b0);
    shift_bits(4, 64'hF, b0, vo);
    check("ir_capture", vo[3:0], 4'b0101);
    tck_cycle(1'b1, 1'b0, b);
    check("ir_bypass", ir_out, 4'hF);
    enter_dr(b0);
    shift_bits(5, 64'b01101, b0, vo);
    check("bypass_stream", vo[4:0], 5'b11010);
    tck_cycle(1'b1, 1'b0, b);

    // USER round trip
    load_ir(4'h8);
    check("ir_user", ir_out, 4'h8);
    enter_dr(b0);
    shift_bits(32, 64'h12345678, b0, vo);
    check("user_capture", vo[31:0], 32'hDEADBEEF);
    p0 = pulse_cnt;
    tck_cycle(1'b1, 1'b0, b);
    check("user_update", user_update_data, 32'h12345678);
    check("user_pulse", pulse_cnt - p0, 1);

    // TLR escape from PauseDR
    load_ir(4'hF);
    walk(8'b01001, 5, b);
    check("pause_state", tap_state, 4'h3);
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, b);
    check("tlr_state", tap_state, 4'hF);
    check("tlr_ir", ir_out, 4'h1);
    check("tlr_no_pulse", pulse_cnt - p0, 0);

    // Mid-shift reset
    enter_dr(b0);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b0, b);
    check("mid_oe_before", tdo_oe, 1'b1);
    settled = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_state", tap_state, 4'hF);
    check("mid_ir", ir_out, 4'h1);
    check("mid_tdo", {tdo, tdo_oe}, 2'b00);
    check("mid_upd", user_update_data, 32'h0);
    model_reset();
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(5);
    settled = 1'b1;
    enter_dr(b0);
    shift_bits(32, 64'd0, b0, vo);
    check("idcode_again", vo[31:0], 32'h149511C3);
    tck_cycle(1'b1, 1'b0, b);

    settled = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
